regfile_mp_sb: RTL and testbench

//  Parametrised 2-read/1-write clocked register file with integrated busy scoreboard.
//  It is the next-generation per-core register file in the quad-core datapath.

---
 rtl/regfile_mp_sb.sv | 120 ++++++++++++
 tb/tb_regfile_mp_sb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// 2-read/1-write register file with registered reads, write-to-read bypass
// and a per-entry busy scoreboard for stalling on pending results.
module regfile_mp_sb #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_rdy,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_rdy,
  output logic              addr_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              rsv_ok;
  logic              err_nxt;

  logic [ADDR_W-1:0] rd_a   [2];
  logic              rd_e   [2];
  logic [DATA_W-1:0] rd_d   [2];
  logic              rd_r   [2];

  logic [DATA_W-1:0] rd0_data_p1, rd1_data_p1;
  logic              rd0_rdy_p1, rd1_rdy_p1;
  logic              addr_err_p1;

  assign wr_ok  = wr_en  && in_range(wr_addr)  && !is_zero(wr_addr);
  assign rsv_ok = rsv_en && in_range(rsv_addr) && !is_zero(rsv_addr);

  assign rd_a[0] = rd0_addr;
  assign rd_a[1] = rd1_addr;
  assign rd_e[0] = rd0_en;
  assign rd_e[1] = rd1_en;

  // Reserve applied after write so a same-entry reserve leaves the entry busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[wr_addr]  = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = mem[rd_a[p]];
      rd_r[p] = !busy_nxt[rd_a[p]];
      if (!in_range(rd_a[p])) begin
        rd_d[p] = '0;
        rd_r[p] = 1'b0;
      end else if (is_zero(rd_a[p])) begin
        rd_d[p] = '0;
        rd_r[p] = 1'b1;
      end else if (wr_ok && (wr_addr == rd_a[p])) begin
        rd_d[p] = wr_data;
      end
    end
  end

  assign err_nxt = (wr_en  && !in_range(wr_addr))  ||
                   (rsv_en && !in_range(rsv_addr)) ||
                   (rd_e[0] && !in_range(rd_a[0])) ||
                   (rd_e[1] && !in_range(rd_a[1]));

  // Stage p1: storage, scoreboard and registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy        <= '0;
      rd0_data_p1 <= '0;
      rd0_rdy_p1  <= 1'b0;
      rd1_data_p1 <= '0;
      rd1_rdy_p1  <= 1'b0;
      addr_err_p1 <= 1'b0;
    end else begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      busy <= busy_nxt;
      if (rd_e[0]) begin
        rd0_data_p1 <= rd_d[0];
        rd0_rdy_p1  <= rd_r[0];
      end
      if (rd_e[1]) begin
        rd1_data_p1 <= rd_d[1];
        rd1_rdy_p1  <= rd_r[1];
      end
      addr_err_p1 <= err_nxt;
    end
  end

  assign rd0_data = rd0_data_p1;
  assign rd0_rdy  = rd0_rdy_p1;
  assign rd1_data = rd1_data_p1;
  assign rd1_rdy  = rd1_rdy_p1;
  assign addr_err = addr_err_p1;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: default 32-entry instance plus a
// 24-entry instance sharing the same stimulus for out-of-range behaviour.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rsv_en, rd0_en, rd1_en;
  logic [4:0]  wr_addr, rsv_addr, rd0_addr, rd1_addr;
  logic [63:0] wr_data;
  logic [63:0] rd0_data, rd1_data, s_rd0_data, s_rd1_data;
  logic        rd0_rdy, rd1_rdy, addr_err, s_rd0_rdy, s_rd1_rdy, s_addr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp_sb dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_rdy(rd0_rdy),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_rdy(rd1_rdy),
    .addr_err(addr_err)
  );

  regfile_mp_sb #(.DEPTH(24)) dut24 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(s_rd0_data), .rd0_rdy(s_rd0_rdy),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(s_rd1_data), .rd1_rdy(s_rd1_rdy),
    .addr_err(s_addr_err)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rd0_en;
    logic [4:0]  rd0_addr;
    logic        rd1_en;
    logic [4:0]  rd1_addr;
    logic [63:0] e0;
    logic        e0r;
    logic [63:0] e1;
    logic        e1r;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; rsv_en = 0; rd0_en = 0; rd1_en = 0;
    wr_addr = 0; rsv_addr = 0; rd0_addr = 0; rd1_addr = 0; wr_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                              input logic re, input logic [4:0] ra,
                              input logic r0e, input logic [4:0] r0a,
                              input logic r1e, input logic [4:0] r1a,
                              input logic [63:0] e0, input logic e0r,
                              input logic [63:0] e1, input logic e1r);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.rsv_en = re; v.rsv_addr = ra;
    v.rd0_en = r0e; v.rd0_addr = r0a; v.rd1_en = r1e; v.rd1_addr = r1a;
    v.e0 = e0; v.e0r = e0r; v.e1 = e1; v.e1r = e1r;
    return v;
  endfunction

  initial begin
    //        we wa  wdata                  re ra  r0e r0a r1e r1a  e0                     e0r e1                     e1r
    vt[0]  = mk(1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0,  0, 0,  0, 0,  64'h0,                 1,  64'h0,                 1);
    vt[1]  = mk(0, 0, 64'h0,                 0, 0,  1, 5,  0, 0,  64'hDEAD_BEEF_0000_0001, 1, 64'h0,                 1);
    vt[2]  = mk(1, 7, 64'h55,                0, 0,  0, 0,  1, 7,  64'hDEAD_BEEF_0000_0001, 1, 64'h55,                1);
    vt[3]  = mk(0, 0, 64'h0,                 1, 9,  1, 9,  0, 0,  64'h0,                 0,  64'h55,                1);
    vt[4]  = mk(0, 0, 64'h0,                 0, 0,  1, 9,  1, 9,  64'h0,                 0,  64'h0,                 0);
    vt[5]  = mk(1, 9, 64'h12,                1, 9,  1, 9,  0, 0,  64'h12,                0,  64'h0,                 0);
    vt[6]  = mk(0, 0, 64'h0,                 0, 0,  1, 9,  0, 0,  64'h12,                0,  64'h0,                 0);
    vt[7]  = mk(1, 9, 64'h34,                0, 0,  0, 0,  1, 9,  64'h12,                0,  64'h34,                1);
    vt[8]  = mk(1, 0, 64'hFF,                0, 0,  1, 0,  1, 0,  64'h0,                 1,  64'h0,                 1);
    vt[9]  = mk(0, 0, 64'h0,                 0, 0,  1, 0,  0, 0,  64'h0,                 1,  64'h0,                 1);
    vt[10] = mk(0, 0, 64'h0,                 1, 0,  1, 0,  0, 0,  64'h0,                 1,  64'h0,                 1);
    vt[11] = mk(0, 0, 64'h0,                 0, 0,  1, 5,  1, 5,  64'hDEAD_BEEF_0000_0001, 1, 64'hDEAD_BEEF_0000_0001, 1);
    vt[12] = mk(1, 31, 64'hABCD,             1, 30, 1, 31, 1, 30, 64'hABCD,              1,  64'h0,                 0);
    vt[13] = mk(1, 30, 64'h1,                0, 0,  0, 0,  1, 30, 64'hABCD,              1,  64'h1,                 1);

    idle();
    rst_n = 1'b0;
    #23;
    chk("reset rd0_data", rd0_data, 64'h0);
    chk("reset rd0_rdy", {63'h0, rd0_rdy}, 64'h0);
    chk("reset rd1_rdy", {63'h0, rd1_rdy}, 64'h0);
    chk("reset addr_err", {63'h0, addr_err}, 64'h0);
    rst_n = 1'b1;
    step();

    for (int a = 0; a < 32; a++) begin
      idle();
      rd0_en = 1; rd0_addr = 5'(a); rd1_en = 1; rd1_addr = 5'(a);
      step();
      chk($sformatf("init rd0 data a%0d", a), rd0_data, 64'h0);
      chk($sformatf("init rd0 rdy a%0d", a), {63'h0, rd0_rdy}, 64'h1);
      chk($sformatf("init rd1 data a%0d", a), rd1_data, 64'h0);
      chk($sformatf("init rd1 rdy a%0d", a), {63'h0, rd1_rdy}, 64'h1);
    end
    idle();
    step();
    chk("init addr_err", {63'h0, addr_err}, 64'h0);

    for (int i = 0; i < 14; i++) begin
      wr_en = vt[i].wr_en; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
      rsv_en = vt[i].rsv_en; rsv_addr = vt[i].rsv_addr;
      rd0_en = vt[i].rd0_en; rd0_addr = vt[i].rd0_addr;
      rd1_en = vt[i].rd1_en; rd1_addr = vt[i].rd1_addr;
      step();
      chk($sformatf("vec%0d rd0_data", i), rd0_data, vt[i].e0);
      chk($sformatf("vec%0d rd0_rdy", i), {63'h0, rd0_rdy}, {63'h0, vt[i].e0r});
      chk($sformatf("vec%0d rd1_data", i), rd1_data, vt[i].e1);
      chk($sformatf("vec%0d rd1_rdy", i), {63'h0, rd1_rdy}, {63'h0, vt[i].e1r});
      chk($sformatf("vec%0d addr_err", i), {63'h0, addr_err}, 64'h0);
    end

    // Out-of-range read on the 24-entry instance.
    idle();
    step();
    chk("d24 idle addr_err", {63'h0, s_addr_err}, 64'h0);
    rd0_en = 1; rd0_addr = 30; rd1_en = 1; rd1_addr = 5;
    step();
    chk("d24 oor rd0_data", s_rd0_data, 64'h0);
    chk("d24 oor rd0_rdy", {63'h0, s_rd0_rdy}, 64'h0);
    chk("d24 rd1_data", s_rd1_data, 64'hDEAD_BEEF_0000_0001);
    chk("d24 rd1_rdy", {63'h0, s_rd1_rdy}, 64'h1);
    chk("d24 addr_err pulse", {63'h0, s_addr_err}, 64'h1);
    chk("d32 addr_err quiet", {63'h0, addr_err}, 64'h0);
    chk("d32 rd0 a30", rd0_data, 64'h1);
    idle();
    step();
    chk("d24 addr_err drop", {63'h0, s_addr_err}, 64'h0);
    chk("d24 rd0_data hold", s_rd0_data, 64'h0);

    // Mid-cycle reset discards earlier writes and reservations.
    idle();
    wr_en = 1; wr_addr = 3; wr_data = 64'hAA; rd0_en = 1; rd0_addr = 3;
    rsv_en = 1; rsv_addr = 4;
    step();
    chk("pre-reset bypass a3", rd0_data, 64'hAA);
    idle();
    rd1_en = 1; rd1_addr = 4;
    step();
    chk("pre-reset a4 busy", {63'h0, rd1_rdy}, 64'h0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset rd0_data", rd0_data, 64'h0);
    chk("async reset rd0_rdy", {63'h0, rd0_rdy}, 64'h0);
    #13 rst_n = 1'b1;
    step();
    rd0_en = 1; rd0_addr = 3; rd1_en = 1; rd1_addr = 4;
    step();
    chk("post-reset a3 data", rd0_data, 64'h0);
    chk("post-reset a3 rdy", {63'h0, rd0_rdy}, 64'h1);
    chk("post-reset a4 data", rd1_data, 64'h0);
    chk("post-reset a4 rdy", {63'h0, rd1_rdy}, 64'h1);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
